multicycle_shifter: RTL
=======================

MULTICYCLE_SHIFTER -- requirements
Module: multicycle_shifter

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 ctrl_shift  input  1  start request; accepted only when state is IDLE.
REQ-005 op  input  1  0 = logical left shift (SLL), 1 = arithmetic right shift (SRA).
REQ-006 data_in  input  32  operand to be shifted.
REQ-007 shamt  input  5  shift amount, 0..31.
REQ-008 data_out  output  32  shift result, registered.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking data_out valid.
REQ-010 busy  output  1  high while an operation is in progress.

Function
REQ-011 The block SHALL implement states IDLE and SHIFT plus a 3-bit stage counter stg (0..4).
REQ-012 IDLE, ctrl_shift=1 at edge N: latch data_in into working register W; latch op and shamt; set stg=0; go to SHIFT.
REQ-013 IDLE, ctrl_shift=0: remain in IDLE; W and data_out unchanged.
REQ-014 SHIFT, at edges N+1..N+5: stage k=stg applies a fixed shift of 16>>k (16, 8, 4, 2, 1) to W iff shamt bit (4-k) is 1; otherwise W passes unchanged.
REQ-015 SRA stages SHALL fill vacated high bits with W[31] as it stands at that stage; SLL stages SHALL fill vacated low bits with 0.
REQ-016 At the stage with stg=4 (edge N+5): the final W value SHALL be written to data_out; data_resultRDY set to 1; state returns to IDLE.
REQ-017 Latency SHALL be fixed at 5 cycles from acceptance, independent of shamt (shamt=0 still takes 5 cycles and returns data_in unmodified).
REQ-018 data_resultRDY SHALL be high for exactly the one cycle following edge N+5 and low otherwise.
REQ-019 busy SHALL be 1 in the cycles following edges N..N+4 and 0 from edge N+5 onward.
REQ-020 ctrl_shift asserted while busy=1 SHALL be ignored: no relatch, no restart, no queueing.
REQ-021 ctrl_shift asserted in the data_resultRDY cycle SHALL be accepted (back-to-back issue); the next result follows 5 cycles later.
REQ-022 data_out SHALL hold its last result until the next completion; changes to data_in/op/shamt after acceptance SHALL NOT affect the result in flight.
REQ-023 No combinational path SHALL exist from any input to any output.

Reset
REQ-024 reset=0 at a rising edge SHALL force state=IDLE, stg=0, W=0, data_out=0x00000000, data_resultRDY=0, busy=0.
REQ-025 reset asserted mid-operation SHALL abort it; no data_resultRDY pulse SHALL be produced for the aborted operation.
REQ-026 reset SHALL take priority over ctrl_shift at the same edge.

Verification
REQ-027 op=1, data_in=0x80000000, shamt=4 -> data_out=0xF8000000 with data_resultRDY one cycle after edge N+5.
REQ-028 op=0, data_in=0x00000001, shamt=31 -> data_out=0x80000000; op=1, data_in=0x7FFFFFF0, shamt=4 -> 0x07FFFFFF.
REQ-029 op=1, data_in=0xDEADBEEF, shamt=0 -> data_out=0xDEADBEEF after exactly 5 cycles.
REQ-030 Start op=0, data_in=0x0000000F, shamt=8; reassert ctrl_shift with data_in=0xFFFFFFFF at N+2 -> single result 0x00000F00, busy low at N+5.
REQ-031 Start at N, drop reset low at N+3 -> all outputs 0 from next cycle, no data_resultRDY; new start after release completes normally.
REQ-032 Back-to-back: second ctrl_shift in data_resultRDY cycle (op=1, 0xFFFF0000, shamt=16) -> second result 0xFFFFFFFF exactly 5 cycles later.

Source files
------------

// File: rtl/multicycle_shifter.sv
// rtl/multicycle_shifter.sv - five-stage iterative 32-bit SLL/SRA shifter
// Fixed 5-cycle latency: one binary-weighted stage (16,8,4,2,1) per clock.
module multicycle_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic        op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] data_out,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] w;
  logic        op_q;
  logic [4:0]  shamt_q;
  logic [2:0]  stg;

  logic [2:0]  bit_idx;
  logic [4:0]  stage_amt;
  logic        stage_en;
  logic [31:0] stage_w;

  // Stage k shifts by 16>>k when shamt bit (4-k) is set; SRA replicates the current sign.
  always_comb begin
    bit_idx   = 3'd4 - stg;
    stage_amt = 5'd16 >> stg;
    stage_en  = shamt_q[bit_idx];
    stage_w   = w;
    if (stage_en) begin
      if (op_q) begin
        stage_w = $signed(w) >>> stage_amt;
      end else begin
        stage_w = w << stage_amt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      stg            <= 3'd0;
      w              <= 32'd0;
      op_q           <= 1'b0;
      shamt_q        <= 5'd0;
      data_out       <= 32'd0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_shift) begin
            w       <= data_in;
            op_q    <= op;
            shamt_q <= shamt;
            stg     <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          w <= stage_w;
          if (stg == 3'd4) begin
            data_out       <= stage_w;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            stg            <= 3'd0;
            state          <= IDLE;
          end else begin
            stg <= stg + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          stg   <= 3'd0;
        end
      endcase
    end
  end

endmodule
